// File: rtl/sim_run_ctrl_if.sv
// Run-control bundle between sim_run_ctrl and the simulation top.
// The master drives stop/event requests; the slave (the sequencer) returns the DUT reset, run window and statistics.
interface sim_run_ctrl_if #(
  parameter int CNT_W = 32,
  parameter int EVT_W = 64
);
  logic             stop_i;
  logic             event_i;
  logic             dut_reset_n;
  logic             run_o;
  logic             done_o;
  logic             timeout_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] cycle_cnt_o;
  logic [EVT_W-1:0] event_cnt_o;

  modport master (
    output stop_i, event_i,
    input  dut_reset_n, run_o, done_o, timeout_o, state_o, cycle_cnt_o, event_cnt_o
  );

  modport slave (
    input  stop_i, event_i,
    output dut_reset_n, run_o, done_o, timeout_o, state_o, cycle_cnt_o, event_cnt_o
  );
endinterface

// File: rtl/sim_run_ctrl.sv
// Simulation run sequencer: HOLD (DUT reset) -> RUN -> DRAIN -> DONE, with saturating cycle/event counters.
// Optional idle timeout (RUN -> DONE with no events) is built when SIM_RUN_CTRL_IDLE_TIMEOUT_EN is defined.
module sim_run_ctrl #(
  parameter int RESET_CYCLES = 11,
  parameter int RUN_CYCLES   = 60,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32,
  parameter int EVT_W        = 64,
  parameter int IDLE_TIMEOUT = 32
) (
  input  logic           i_clk,
  input  logic           reset,
  sim_run_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int HOLD_W  = $clog2(RESET_CYCLES + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST  = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]   RUN_LAST    = CNT_W'(RUN_CYCLES - 1);
  localparam bit                 RUN_LIMITED = (RUN_CYCLES != 0);

  state_t             state_q,     state_d;
  logic [HOLD_W-1:0]  hold_cnt_q,  hold_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [EVT_W-1:0]   event_cnt_q, event_cnt_d;
  logic               dut_rstn_q,  dut_rstn_d;
  logic               run_q,       run_d;
  logic               done_q,      done_d;
  logic               run_exit;

`ifdef SIM_RUN_CTRL_IDLE_TIMEOUT_EN
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              timeout_q,  timeout_d;
`endif

  // Budget exit compares the pre-increment count so the exiting cycle is still counted.
  assign run_exit = bus.stop_i || (RUN_LIMITED && (cycle_cnt_q == RUN_LAST));

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    drain_cnt_d = drain_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    event_cnt_d = event_cnt_q;
    dut_rstn_d  = dut_rstn_q;
    run_d       = run_q;
    done_d      = done_q;
`ifdef SIM_RUN_CTRL_IDLE_TIMEOUT_EN
    idle_cnt_d  = idle_cnt_q;
    timeout_d   = timeout_q;
`endif

    case (state_q)
      HOLD: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = RUN;
          dut_rstn_d = 1'b1;
          run_d      = 1'b1;
`ifdef SIM_RUN_CTRL_IDLE_TIMEOUT_EN
          idle_cnt_d = '0;
`endif
        end
      end

      RUN: begin
        if (cycle_cnt_q != {CNT_W{1'b1}}) begin
          cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if (bus.event_i && (event_cnt_q != {EVT_W{1'b1}})) begin
          event_cnt_d = event_cnt_q + EVT_W'(1);
        end
`ifdef SIM_RUN_CTRL_IDLE_TIMEOUT_EN
        idle_cnt_d = bus.event_i ? '0 : idle_cnt_q + IDLE_W'(1);
`endif
        if (run_exit) begin
          state_d = DRAIN;
          run_d   = 1'b0;
`ifdef SIM_RUN_CTRL_IDLE_TIMEOUT_EN
        end else if (!bus.event_i && (idle_cnt_q == IDLE_LAST)) begin
          // Idle timeout skips DRAIN; a simultaneous stop or budget exit takes priority above.
          state_d   = DONE;
          run_d     = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
`endif
        end
      end

      DRAIN: begin
        if (bus.event_i && (event_cnt_q != {EVT_W{1'b1}})) begin
          event_cnt_d = event_cnt_q + EVT_W'(1);
        end
        drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_q     <= HOLD;
      hold_cnt_q  <= '0;
      drain_cnt_q <= '0;
      cycle_cnt_q <= '0;
      event_cnt_q <= '0;
      dut_rstn_q  <= 1'b0;
      run_q       <= 1'b0;
      done_q      <= 1'b0;
`ifdef SIM_RUN_CTRL_IDLE_TIMEOUT_EN
      idle_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      event_cnt_q <= event_cnt_d;
      dut_rstn_q  <= dut_rstn_d;
      run_q       <= run_d;
      done_q      <= done_d;
`ifdef SIM_RUN_CTRL_IDLE_TIMEOUT_EN
      idle_cnt_q  <= idle_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign bus.dut_reset_n = dut_rstn_q;
  assign bus.run_o       = run_q;
  assign bus.done_o      = done_q;
  assign bus.state_o     = state_q;
  assign bus.cycle_cnt_o = cycle_cnt_q;
  assign bus.event_cnt_o = event_cnt_q;
`ifdef SIM_RUN_CTRL_IDLE_TIMEOUT_EN
  assign bus.timeout_o   = timeout_q;
`else
  assign bus.timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: vector table, abort-on-reset and random runs against a timeline model,
// plus a narrow-counter instance for saturation with an unlimited run budget.
module tb_sim_run_ctrl;

  localparam int R    = 11;
  localparam int RC   = 60;
  localparam int D    = 4;
  localparam int IT   = 8;
  localparam int NMAX = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  sim_run_ctrl_if #(.CNT_W(32), .EVT_W(64)) bus_a ();
  sim_run_ctrl_if #(.CNT_W(4),  .EVT_W(4))  bus_b ();

  sim_run_ctrl #(
    .RESET_CYCLES(R), .RUN_CYCLES(RC), .DRAIN_CYCLES(D),
    .CNT_W(32), .EVT_W(64), .IDLE_TIMEOUT(IT)
  ) dut_a (
    .i_clk(clk), .reset(rst_a), .bus(bus_a)
  );

  sim_run_ctrl #(
    .RESET_CYCLES(R), .RUN_CYCLES(0), .DRAIN_CYCLES(D),
    .CNT_W(4), .EVT_W(4), .IDLE_TIMEOUT(IT)
  ) dut_b (
    .i_clk(clk), .reset(rst_b), .bus(bus_b)
  );

  typedef struct {
    int stop_at;     // RUN cycle (0-based) of a one-cycle stop pulse, -1 none, -2 random
    bit stop_hold;   // stop_i held high throughout HOLD
    int ev_mode;     // 0 none, 1 every cycle, 2 single on RUN cycle 2, 3 random
    int exp_cyc;
    int exp_evt;
    int exp_done_edge;
    int exp_to;
  } vec_t;

  typedef struct {
    int     rstn, run, done, tmo, st;
    longint cyc, evt;
  } exp_t;

  int n_pass  = 0;
  int n_total = 0;
  bit stop_h [NMAX+1];
  bit ev_h   [NMAX+1];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int count_ev(input int lo, input int hi);
    int c = 0;
    for (int e = lo; e <= hi; e++) c += int'(ev_h[e]);
    return c;
  endfunction

  // Expected outputs after posedge n (n=0: in reset), derived from the recorded input timeline.
  function automatic exp_t model(input int n);
    exp_t x;
    int   run_end;
    bit   tmo;
`ifdef SIM_RUN_CTRL_IDLE_TIMEOUT_EN
    int   last_ev;
    last_ev = R;
`endif
    x = '{default: 0};
    if (n < R) return x;
    x.rstn  = 1;
    run_end = 0;
    tmo     = 1'b0;
    for (int e = R + 1; e <= n; e++) begin
      if (stop_h[e] || (RC != 0 && e - R == RC)) begin
        run_end = e;
        break;
      end
`ifdef SIM_RUN_CTRL_IDLE_TIMEOUT_EN
      if (!ev_h[e] && (e - last_ev == IT)) begin
        run_end = e;
        tmo     = 1'b1;
        break;
      end
      if (ev_h[e]) last_ev = e;
`endif
    end
    if (run_end == 0) begin
      x.st = 1; x.run = 1; x.cyc = n - R; x.evt = count_ev(R + 1, n);
    end else if (tmo) begin
      x.st = 3; x.done = 1; x.tmo = 1; x.cyc = run_end - R; x.evt = count_ev(R + 1, run_end);
    end else if (n < run_end + D) begin
      x.st = 2; x.cyc = run_end - R; x.evt = count_ev(R + 1, n);
    end else begin
      x.st = 3; x.done = 1; x.cyc = run_end - R; x.evt = count_ev(R + 1, run_end + D);
    end
    return x;
  endfunction

  task automatic check_edge(input int n);
    exp_t x;
    x = model(n);
    check($sformatf("e%0d dut_reset_n", n), longint'(bus_a.dut_reset_n), x.rstn);
    check($sformatf("e%0d run_o", n),       longint'(bus_a.run_o),       x.run);
    check($sformatf("e%0d done_o", n),      longint'(bus_a.done_o),      x.done);
    check($sformatf("e%0d timeout_o", n),   longint'(bus_a.timeout_o),   x.tmo);
    check($sformatf("e%0d state_o", n),     longint'(bus_a.state_o),     x.st);
    check($sformatf("e%0d cycle_cnt", n),   longint'(bus_a.cycle_cnt_o), x.cyc);
    check($sformatf("e%0d event_cnt", n),   longint'(bus_a.event_cnt_o), x.evt);
  endtask

  task automatic run_scenario(input int stop_at, input bit stop_hold, input int ev_mode,
                              input int n_edges, input int abort_edge, output int first_done);
    bit st, ev;
    rst_a = 1'b1;
    bus_a.stop_i  = 1'b0;
    bus_a.event_i = 1'b0;
    for (int i = 0; i <= NMAX; i++) begin
      stop_h[i] = 1'b0;
      ev_h[i]   = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    check_edge(0);
    rst_a      = 1'b0;
    first_done = -1;
    for (int e = 1; e <= n_edges; e++) begin
      if (stop_at == -2) st = ($urandom_range(0, 29) == 0);
      else               st = (stop_at >= 0 && e == R + 1 + stop_at) || (stop_hold && e <= R);
      case (ev_mode)
        1:       ev = 1'b1;
        2:       ev = (e == R + 3);
        3:       ev = 1'($urandom_range(0, 1));
        default: ev = 1'b0;
      endcase
      bus_a.stop_i  = st;
      bus_a.event_i = ev;
      stop_h[e]     = st;
      ev_h[e]       = ev;
      @(posedge clk);
      #1;
      check_edge(e);
      if (first_done < 0 && bus_a.done_o) first_done = e;
      if (e == abort_edge) begin
        #2 rst_a = 1'b1;
        #1;
        check_edge(0);
        break;
      end
      @(negedge clk);
    end
    $display("run stop_at=%0d hold=%0d ev_mode=%0d edges=%0d done_edge=%0d cyc=%0d evt=%0d",
             stop_at, stop_hold, ev_mode, n_edges, first_done, bus_a.cycle_cnt_o, bus_a.event_cnt_o);
  endtask

  vec_t vecs [4];
  int   fd;

  initial begin
    bus_b.stop_i  = 1'b0;
    bus_b.event_i = 1'b0;

`ifdef SIM_RUN_CTRL_IDLE_TIMEOUT_EN
    vecs[0] = '{-1, 1'b0, 0,  8,  0, 19, 1};
    vecs[1] = '{-1, 1'b0, 1, 60, 64, 75, 0};
    vecs[2] = '{10, 1'b1, 1, 11, 15, 26, 0};
    vecs[3] = '{-1, 1'b1, 2, 11,  1, 22, 1};
`else
    vecs[0] = '{-1, 1'b0, 0, 60,  0, 75, 0};
    vecs[1] = '{-1, 1'b0, 1, 60, 64, 75, 0};
    vecs[2] = '{10, 1'b0, 0, 11,  0, 26, 0};
    vecs[3] = '{10, 1'b1, 1, 11, 15, 26, 0};
`endif

    // Reset reasserted mid-RUN (RUN cycle 20), no clock edge before the check.
    run_scenario(-1, 1'b0, 1, 100, R + 1 + 20, fd);

    foreach (vecs[i]) begin
      run_scenario(vecs[i].stop_at, vecs[i].stop_hold, vecs[i].ev_mode, 90, 0, fd);
      check($sformatf("vec%0d done_edge", i), fd,                          vecs[i].exp_done_edge);
      check($sformatf("vec%0d cycle_cnt", i), longint'(bus_a.cycle_cnt_o), vecs[i].exp_cyc);
      check($sformatf("vec%0d event_cnt", i), longint'(bus_a.event_cnt_o), vecs[i].exp_evt);
      check($sformatf("vec%0d timeout", i),   longint'(bus_a.timeout_o),   vecs[i].exp_to);
      check($sformatf("vec%0d state", i),     longint'(bus_a.state_o),     3);
    end

    for (int i = 0; i < 6; i++) begin
      run_scenario(-2, 1'b0, 3, 100, 0, fd);
    end

    // Narrow counters, unlimited budget: saturation, then stop ends the run.
    @(negedge clk);
    check("b reset dut_reset_n", longint'(bus_b.dut_reset_n), 0);
    check("b reset state",       longint'(bus_b.state_o),     0);
    bus_b.event_i = 1'b1;
    rst_b = 1'b0;
    repeat (R + 20) @(posedge clk);
    #1;
    check("b sat state",     longint'(bus_b.state_o),     1);
    check("b sat run_o",     longint'(bus_b.run_o),       1);
    check("b sat rstn",      longint'(bus_b.dut_reset_n), 1);
    check("b sat cycle_cnt", longint'(bus_b.cycle_cnt_o), 15);
    check("b sat event_cnt", longint'(bus_b.event_cnt_o), 15);
    $display("b saturate cyc=%0d evt=%0d", bus_b.cycle_cnt_o, bus_b.event_cnt_o);
    @(negedge clk);
    bus_b.stop_i = 1'b1;
    @(posedge clk);
    #1;
    check("b stop state", longint'(bus_b.state_o), 2);
    check("b stop run_o", longint'(bus_b.run_o),   0);
    @(negedge clk);
    bus_b.stop_i = 1'b0;
    repeat (D) @(posedge clk);
    #1;
    check("b done state",     longint'(bus_b.state_o),     3);
    check("b done done_o",    longint'(bus_b.done_o),      1);
    check("b done cycle_cnt", longint'(bus_b.cycle_cnt_o), 15);
    check("b done event_cnt", longint'(bus_b.event_cnt_o), 15);
    $display("b stop/drain state=%0d done=%0d", bus_b.state_o, bus_b.done_o);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
